// File: rtl/cond_eval_pkg.sv
// Shared types and constants for the condition evaluator: condition codes,
// flag bit positions and FSM state encoding.
package cond_eval_pkg;

   localparam int unsigned NUM_FLAGS = 4;

   localparam int unsigned Z_IDX = 0;
   localparam int unsigned C_IDX = 1;
   localparam int unsigned N_IDX = 2;
   localparam int unsigned V_IDX = 3;

   typedef enum logic [3:0] {
      EQ = 4'h0,
      NE = 4'h1,
      CS = 4'h2,
      CC = 4'h3,
      MI = 4'h4,
      PL = 4'h5,
      VS = 4'h6,
      VC = 4'h7,
      HI = 4'h8,
      LS = 4'h9,
      GE = 4'hA,
      LT = 4'hB,
      GT = 4'hC,
      LE = 4'hD,
      AL = 4'hE,
      NV = 4'hF
   } cond_t;

   // One-entry response slot: EMPTY or FULL.
   typedef logic [0:0] state_t;
   localparam state_t ST_EMPTY = 1'b0;
   localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/cond_eval_decode.sv
// Purely combinational condition-code decoder over the four ALU flags.
module cond_decode
   import cond_eval_pkg::*;
(
   input  logic [3:0]           cond,
   input  logic [NUM_FLAGS-1:0] flags,
   output logic                 pass
);

   logic z, c, n, v;

   assign z = flags[Z_IDX];
   assign c = flags[C_IDX];
   assign n = flags[N_IDX];
   assign v = flags[V_IDX];

   always_comb begin
      pass = 1'b0;
      unique case (cond_t'(cond))
         EQ: pass = z;
         NE: pass = !z;
         CS: pass = c;
         CC: pass = !c;
         MI: pass = n;
         PL: pass = !n;
         VS: pass = v;
         VC: pass = !v;
         HI: pass = c & !z;
         LS: pass = !c | z;
         GE: pass = (n == v);
         LT: pass = (n != v);
         GT: pass = !z & (n == v);
         LE: pass = z | (n != v);
         AL: pass = 1'b1;
         NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_eval.sv
// Condition evaluator: holds ALU flags, evaluates condition requests into a
// one-entry registered response slot, and counts consumed pass/fail results.
module cond_eval
   import cond_eval_pkg::*;
#(
   parameter int unsigned FORWARD = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flag_we,
   input  logic                 d_zero,
   input  logic                 d_carry,
   input  logic                 d_negative,
   input  logic                 d_overflow,
   input  logic                 req_valid,
   input  logic [3:0]           req_cond,
   output logic                 req_ready,
   output logic                 resp_valid,
   output logic                 resp_pass,
   input  logic                 resp_ready,
   output logic [NUM_FLAGS-1:0] flags_q,
   input  logic                 clr_cnt,
   output logic [CNT_W-1:0]     pass_cnt,
   output logic [CNT_W-1:0]     fail_cnt
);

   state_t               state_q, state_d;
   logic                 pass_q;
   logic [NUM_FLAGS-1:0] d_flags;
   logic [NUM_FLAGS-1:0] eval_flags;
   logic                 eval_pass;
   logic                 accept;
   logic                 consume;

   assign d_flags = {d_overflow, d_negative, d_carry, d_zero};

   // Forwarding lets a request see flags written in its own accept cycle.
   assign eval_flags = ((FORWARD != 0) && flag_we) ? d_flags : flags_q;

   cond_decode u_decode (
      .cond  (req_cond),
      .flags (eval_flags),
      .pass  (eval_pass)
   );

   assign resp_valid = (state_q == ST_FULL);
   assign resp_pass  = pass_q;
   assign req_ready  = (state_q == ST_EMPTY) | resp_ready;
   assign accept     = req_valid & req_ready;
   assign consume    = resp_valid & resp_ready;

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = ST_FULL;
      end else if (consume) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
         pass_q  <= 1'b0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pass_q <= eval_pass;
         end
         if (flag_we) begin
            flags_q <= d_flags;
         end
      end
   end

   // Saturating statistics; clear wins over a same-cycle consumption.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else if (clr_cnt) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else if (consume) begin
         if (pass_q) begin
            if (pass_cnt != {CNT_W{1'b1}}) begin
               pass_cnt <= pass_cnt + CNT_W'(1);
            end
         end else begin
            if (fail_cnt != {CNT_W{1'b1}}) begin
               fail_cnt <= fail_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_cond_eval.sv
// Self-checking bench for cond_eval: three instances (default, no forwarding,
// 2-bit counters) share stimulus and are checked against a behavioural model.
module tb_cond_eval;

   logic       clk;
   logic       rst;
   logic       flag_we;
   logic       d_zero, d_carry, d_negative, d_overflow;
   logic       req_valid;
   logic [3:0] req_cond;
   logic       resp_ready;
   logic       clr_cnt;

   logic        req_ready  [3];
   logic        resp_valid [3];
   logic        resp_pass  [3];
   logic [3:0]  flags_q    [3];
   logic [15:0] pass_cnt   [3];
   logic [15:0] fail_cnt   [3];
   logic [15:0] pc_nf, fc_nf;
   logic [1:0]  pc_c2, fc_c2;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance.
   bit m_full  [3];
   bit m_pass  [3];
   bit [3:0] m_flags [3];
   int m_pc    [3];
   int m_fc    [3];
   bit m_fwd   [3] = '{1'b1, 1'b0, 1'b1};
   int m_max   [3] = '{65535, 65535, 3};

   cond_eval u_dut (
      .clk(clk), .rst(rst), .flag_we(flag_we),
      .d_zero(d_zero), .d_carry(d_carry), .d_negative(d_negative), .d_overflow(d_overflow),
      .req_valid(req_valid), .req_cond(req_cond), .req_ready(req_ready[0]),
      .resp_valid(resp_valid[0]), .resp_pass(resp_pass[0]), .resp_ready(resp_ready),
      .flags_q(flags_q[0]), .clr_cnt(clr_cnt), .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0])
   );

   cond_eval #(.FORWARD(0)) u_dut_nf (
      .clk(clk), .rst(rst), .flag_we(flag_we),
      .d_zero(d_zero), .d_carry(d_carry), .d_negative(d_negative), .d_overflow(d_overflow),
      .req_valid(req_valid), .req_cond(req_cond), .req_ready(req_ready[1]),
      .resp_valid(resp_valid[1]), .resp_pass(resp_pass[1]), .resp_ready(resp_ready),
      .flags_q(flags_q[1]), .clr_cnt(clr_cnt), .pass_cnt(pc_nf), .fail_cnt(fc_nf)
   );

   cond_eval #(.CNT_W(2)) u_dut_c2 (
      .clk(clk), .rst(rst), .flag_we(flag_we),
      .d_zero(d_zero), .d_carry(d_carry), .d_negative(d_negative), .d_overflow(d_overflow),
      .req_valid(req_valid), .req_cond(req_cond), .req_ready(req_ready[2]),
      .resp_valid(resp_valid[2]), .resp_pass(resp_pass[2]), .resp_ready(resp_ready),
      .flags_q(flags_q[2]), .clr_cnt(clr_cnt), .pass_cnt(pc_c2), .fail_cnt(fc_c2)
   );

   assign pass_cnt[1] = pc_nf;
   assign fail_cnt[1] = fc_nf;
   assign pass_cnt[2] = {14'd0, pc_c2};
   assign fail_cnt[2] = {14'd0, fc_c2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Condition truth from pairs: even code is the base test, odd code its negation.
   function automatic bit ref_eval(input int c, input bit [3:0] f);
      bit z, cy, n, v, b;
      z = f[0]; cy = f[1]; n = f[2]; v = f[3];
      case (c / 2)
         0: b = z;
         1: b = cy;
         2: b = n;
         3: b = v;
         4: b = cy && !z;
         5: b = (n == v);
         6: b = !z && (n == v);
         default: b = 1'b1;
      endcase
      return (c % 2 == 1) ? !b : b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_full[i] = 0; m_pass[i] = 0; m_flags[i] = 4'h0; m_pc[i] = 0; m_fc[i] = 0;
      end
   endtask

   task automatic model_edge();
      bit [3:0] d;
      bit ready, acc, cons;
      d = {d_overflow, d_negative, d_carry, d_zero};
      for (int i = 0; i < 3; i++) begin
         ready = !m_full[i] || resp_ready;
         acc   = req_valid && ready;
         cons  = m_full[i] && resp_ready;
         if (clr_cnt) begin
            m_pc[i] = 0; m_fc[i] = 0;
         end else if (cons) begin
            if (m_pass[i]) m_pc[i] = (m_pc[i] < m_max[i]) ? m_pc[i] + 1 : m_max[i];
            else           m_fc[i] = (m_fc[i] < m_max[i]) ? m_fc[i] + 1 : m_max[i];
         end
         if (acc) begin
            m_pass[i] = ref_eval(int'(req_cond), (m_fwd[i] && flag_we) ? d : m_flags[i]);
            m_full[i] = 1;
         end else if (cons) begin
            m_full[i] = 0;
         end
         if (flag_we) m_flags[i] = d;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("resp_valid[%0d]", i), 32'(resp_valid[i]), 32'(m_full[i]));
         chk($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(!m_full[i] || resp_ready));
         if (m_full[i]) chk($sformatf("resp_pass[%0d]", i), 32'(resp_pass[i]), 32'(m_pass[i]));
         chk($sformatf("flags_q[%0d]", i), 32'(flags_q[i]), 32'(m_flags[i]));
         chk($sformatf("pass_cnt[%0d]", i), 32'(pass_cnt[i]), 32'(m_pc[i]));
         chk($sformatf("fail_cnt[%0d]", i), 32'(fail_cnt[i]), 32'(m_fc[i]));
      end
   endtask

   // Inputs are driven just after an edge; check then advance one clock.
   task automatic tick();
      #1;
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit we, input bit [3:0] f, input bit rv, input int c,
                        input bit rr, input bit clr);
      flag_we = we;
      {d_overflow, d_negative, d_carry, d_zero} = f;
      req_valid = rv; req_cond = 4'(c); resp_ready = rr; clr_cnt = clr;
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 4'h0, 0, 0, 0, 0);
      model_reset();
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("rst_valid", 32'(resp_valid[i]), 0);
         chk("rst_pass", 32'(resp_pass[i]), 0);
         chk("rst_flags", 32'(flags_q[i]), 0);
         chk("rst_pcnt", 32'(pass_cnt[i]), 0);
         chk("rst_fcnt", 32'(fail_cnt[i]), 0);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 32'(req_ready[0]), 1);

      // Z set, then EQ then NE.
      drive(1, 4'b0001, 0, 0, 1, 0); tick();
      drive(0, 4'h0, 1, 4'h0, 1, 0); tick();
      drive(0, 4'h0, 1, 4'h1, 1, 0);
      #1 chk("eq_valid", 32'(resp_valid[0]), 1);
      chk("eq_pass", 32'(resp_pass[0]), 1);
      tick();
      drive(0, 4'h0, 0, 0, 1, 0);
      #1 chk("ne_pass", 32'(resp_pass[0]), 0);
      tick();

      // Forwarding: flags cleared, then N=1 written alongside an LT request.
      drive(1, 4'h0, 0, 0, 1, 0); tick();
      drive(1, 4'b0100, 1, 4'hB, 1, 0); tick();
      drive(0, 4'h0, 0, 0, 0, 0);
      #1 chk("lt_fwd", 32'(resp_pass[0]), 1);
      chk("lt_nofwd", 32'(resp_pass[1]), 0);
      tick();

      // Stall with a pending result while flags change underneath it.
      drive(0, 4'h0, 1, 4'hE, 0, 0); tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, 4'($urandom_range(0, 15)), 1, 4'hF, 0, 0);
         #1 chk("stall_ready", 32'(req_ready[0]), 0);
         chk("stall_pass", 32'(resp_pass[0]), 1);
         tick();
      end
      drive(0, 4'h0, 0, 0, 1, 0); tick();
      drive(0, 4'h0, 0, 0, 1, 0); tick();

      // Back-to-back AL/NV/AL/NV.
      drive(0, 4'h0, 0, 0, 1, 1); tick();
      for (int k = 0; k < 4; k++) begin
         drive(0, 4'h0, 1, (k % 2 == 0) ? 14 : 15, 1, 0); tick();
      end
      drive(0, 4'h0, 0, 0, 1, 0); tick();
      #1 chk("b2b_pass_cnt", 32'(pass_cnt[0]), 2);
      chk("b2b_fail_cnt", 32'(fail_cnt[0]), 2);

      // Saturation on the 2-bit instance, then clear against a consumption.
      drive(0, 4'h0, 0, 0, 1, 1); tick();
      for (int k = 0; k < 5; k++) begin
         drive(0, 4'h0, 1, 14, 1, 0); tick();
      end
      drive(0, 4'h0, 0, 0, 1, 0); tick();
      #1 chk("sat_c2", 32'(pass_cnt[2]), 3);
      chk("sat_wide", 32'(pass_cnt[0]), 5);
      drive(0, 4'h0, 1, 14, 0, 0); tick();
      drive(0, 4'h0, 0, 0, 1, 1); tick();
      #1 chk("clr_pass", 32'(pass_cnt[0]), 0);
      chk("clr_fail", 32'(fail_cnt[0]), 0);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
         tick();
      end

      // Asynchronous reset while FULL.
      drive(1, 4'hF, 1, 14, 0, 0); tick();
      drive(0, 4'h0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_valid", 32'(resp_valid[i]), 0);
         chk("mid_rst_flags", 32'(flags_q[i]), 0);
         chk("mid_rst_pcnt", 32'(pass_cnt[i]), 0);
         chk("mid_rst_fcnt", 32'(fail_cnt[i]), 0);
      end
      model_reset();
      #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_mid_rst", 32'(req_ready[0]), 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
